// File: rtl/pwm_divider_bank_if.sv
// Configuration write bus for pwm_divider_bank: valid/ready handshake carrying
// a channel index plus the period, high-time and enable fields for that channel.
interface pwm_divider_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             valid;
  logic             ready;
  logic [CW-1:0]    chan;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high;
  logic             enable;

  modport master (output valid, chan, period, high, enable, input ready);
  modport slave  (input valid, chan, period, high, enable, output ready);
endinterface

// File: rtl/pwm_divider_bank.sv
// Bank of independent counter-based PWM / clock dividers. Writes to a running
// channel are staged in a shadow set and swapped in at the period wrap.
module pwm_divider_bank #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 16,
  parameter int DEFAULT_PERIOD = 390
) (
  input  logic                clock_i,
  input  logic                reset_i,
  pwm_divider_bank_if.slave   cfg,
  output logic [CHANNELS-1:0] pwm_out_o,
  output logic [CHANNELS-1:0] period_tick_o
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] RST_PER  = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_PERIOD / 2);

  logic [CHANNELS-1:0] pend_vec;

  // Out-of-range channel indices match no lane, so they stay ready and are dropped.
  always_comb begin
    cfg.ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++)
      if (cfg.chan == CW'(c) && pend_vec[c]) cfg.ready = 1'b0;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] per_q, per_d, high_q, high_d, cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_per_q, sh_per_d, sh_high_q, sh_high_d;
    logic             en_q, en_d, sh_en_q, sh_en_d, pend_q, pend_d;
    logic             pwm_q, pwm_d, tick_q, tick_d;
    logic             wr, wrap;

    assign wr   = cfg.valid && cfg.ready && (cfg.chan == CW'(c));
    assign wrap = en_q && (cnt_q == per_q);

    always_comb begin
      per_d     = per_q;
      high_d    = high_q;
      en_d      = en_q;
      sh_per_d  = sh_per_q;
      sh_high_d = sh_high_q;
      sh_en_d   = sh_en_q;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      pwm_d     = en_q && (cnt_q < high_q);
      tick_d    = wrap;
      if (!en_q) begin
        // Idle channel: nothing to protect, so writes land immediately.
        cnt_d = '0;
        if (wr) begin
          per_d     = cfg.period;
          high_d    = cfg.high;
          en_d      = cfg.enable;
          sh_per_d  = cfg.period;
          sh_high_d = cfg.high;
          sh_en_d   = cfg.enable;
        end
      end else if (wrap) begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (wr) begin
          per_d     = cfg.period;
          high_d    = cfg.high;
          en_d      = cfg.enable;
          sh_per_d  = cfg.period;
          sh_high_d = cfg.high;
          sh_en_d   = cfg.enable;
        end else if (pend_q) begin
          per_d  = sh_per_q;
          high_d = sh_high_q;
          en_d   = sh_en_q;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (wr) begin
          sh_per_d  = cfg.period;
          sh_high_d = cfg.high;
          sh_en_d   = cfg.enable;
          pend_d    = 1'b1;
        end
      end
    end

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        per_q     <= RST_PER;
        high_q    <= RST_HIGH;
        en_q      <= 1'b1;
        sh_per_q  <= RST_PER;
        sh_high_q <= RST_HIGH;
        sh_en_q   <= 1'b1;
        pend_q    <= 1'b0;
        cnt_q     <= '0;
        pwm_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        per_q     <= per_d;
        high_q    <= high_d;
        en_q      <= en_d;
        sh_per_q  <= sh_per_d;
        sh_high_q <= sh_high_d;
        sh_en_q   <= sh_en_d;
        pend_q    <= pend_d;
        cnt_q     <= cnt_d;
        pwm_q     <= pwm_d;
        tick_q    <= tick_d;
      end
    end

    assign pend_vec[c]      = pend_q;
    assign pwm_out_o[c]     = pwm_q;
    assign period_tick_o[c] = tick_q;
  end
endmodule

// File: tb/tb_pwm_divider_bank.sv
// Directed bench for pwm_divider_bank: checkpoint table over the default
// waveform, then hand sequences for reconfiguration corner cases.
module tb_pwm_divider_bank;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pwm, tick;
  int         nvec = 0;
  int         nmis = 0;
  int         edge_n = 0;

  pwm_divider_bank_if #(.CHANNELS(4), .WIDTH(16)) cfg ();

  pwm_divider_bank #(.CHANNELS(4), .WIDTH(16), .DEFAULT_PERIOD(390)) dut (
    .clock_i(clk), .reset_i(rst), .cfg(cfg),
    .pwm_out_o(pwm), .period_tick_o(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  typedef struct {
    int         at_edge;
    logic [3:0] exp_pwm;
    logic [3:0] exp_tick;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic rdy_of(input int ch, output logic r);
    cfg.chan = 2'(ch);
    #1;
    r = cfg.ready;
  endtask

  task automatic do_reset(input int ch);
    logic r;
    rst = 1'b1;
    cfg.valid = 1'b1; cfg.chan = 2'(ch);
    cfg.period = 16'd2; cfg.high = 16'd1; cfg.enable = 1'b0;
    step(); step();
    chk("reset_pwm", 32'(pwm), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    cfg.valid = 1'b0;
    rdy_of(ch, r);
    chk("reset_ready", 32'(r), 32'h1);
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic cfg_write(input int ch, input int p, input int h, input bit en);
    cfg.valid = 1'b1; cfg.chan = 2'(ch);
    cfg.period = 16'(p); cfg.high = 16'(h); cfg.enable = en;
    #1;
    chk("write_ready", 32'(cfg.ready), 32'h1);
    step();
    cfg.valid = 1'b0;
  endtask

  task automatic wait_applied(input int ch);
    logic r;
    int   n = 0;
    rdy_of(ch, r);
    while (!r && n < 1000) begin
      step();
      rdy_of(ch, r);
      n++;
    end
    chk("applied_in_time", 32'(r), 32'h1);
  endtask

  task automatic capture(input int ch, input int n, output logic [31:0] pw, output logic [31:0] tk);
    pw = '0; tk = '0;
    for (int i = 0; i < n; i++) begin
      step();
      pw[i] = pwm[ch];
      tk[i] = tick[ch];
    end
  endtask

  vec_t        tbl[11];
  logic [31:0] pw, tk;
  logic        r;

  initial begin
    tbl[0]  = '{1,   4'hF, 4'h0};
    tbl[1]  = '{195, 4'hF, 4'h0};
    tbl[2]  = '{196, 4'h0, 4'h0};
    tbl[3]  = '{390, 4'h0, 4'h0};
    tbl[4]  = '{391, 4'h0, 4'hF};
    tbl[5]  = '{392, 4'hF, 4'h0};
    tbl[6]  = '{586, 4'hF, 4'h0};
    tbl[7]  = '{587, 4'h0, 4'h0};
    tbl[8]  = '{781, 4'h0, 4'h0};
    tbl[9]  = '{782, 4'h0, 4'hF};
    tbl[10] = '{783, 4'hF, 4'h0};
    cfg.valid = 1'b0; cfg.chan = '0; cfg.period = '0; cfg.high = '0; cfg.enable = 1'b0;

    // Default waveform after reset: 195 high, 196 low, tick every 391.
    do_reset(1);
    foreach (tbl[i]) begin
      run_to(tbl[i].at_edge);
      chk("default_pwm", 32'(pwm), 32'(tbl[i].exp_pwm));
      chk("default_tick", 32'(tick), 32'(tbl[i].exp_tick));
    end

    // Mid-period reconfig of ch1, blocked second write, swap at the wrap.
    do_reset(1);
    run_to(100);
    cfg_write(1, 9, 3, 1);
    cfg.valid = 1'b1; cfg.period = 16'd20; cfg.high = 16'd10; cfg.enable = 1'b1;
    rdy_of(1, r);
    chk("pending_ready_ch1", 32'(r), 32'h0);
    cfg.valid = 1'b0;
    rdy_of(2, r);
    chk("pending_ready_ch2", 32'(r), 32'h1);
    cfg.valid = 1'b1; cfg.chan = 2'd1;
    step();
    cfg.valid = 1'b0;
    run_to(195);
    chk("old_wave_high", 32'(pwm[1]), 32'h1);
    run_to(196);
    chk("old_wave_low", 32'(pwm[1]), 32'h0);
    run_to(390);
    rdy_of(1, r);
    chk("ready_before_wrap", 32'(r), 32'h0);
    run_to(391);
    rdy_of(1, r);
    chk("ready_after_wrap", 32'(r), 32'h1);
    chk("wrap_tick_all", 32'(tick), 32'hF);
    capture(1, 20, pw, tk);
    chk("ch1_p9h3_pwm", pw, 32'b0000000111_0000000111);
    chk("ch1_p9h3_tick", tk, 32'b1000000000_1000000000);
    chk("others_undisturbed", 32'(pwm), 32'b1101);

    // Write landing in the wrap cycle, then edge values of H and P on ch0.
    do_reset(0);
    run_to(390);
    cfg_write(0, 5, 2, 1);
    chk("wrapwrite_tick", 32'(tick), 32'hF);
    chk("wrapwrite_pwm0", 32'(pwm[0]), 32'h0);
    capture(0, 12, pw, tk);
    chk("p5h2_pwm", pw, 32'b000011000011);
    chk("p5h2_tick", tk, 32'b100000100000);
    cfg_write(0, 5, 0, 1);
    wait_applied(0);
    capture(0, 12, pw, tk);
    chk("h0_pwm", pw, 32'h000);
    chk("h0_tick", tk, 32'b100000100000);
    cfg_write(0, 4, 7, 1);
    wait_applied(0);
    capture(0, 12, pw, tk);
    chk("hgtp_pwm", pw, 32'hFFF);
    chk("hgtp_tick", tk, 32'h210);
    cfg_write(0, 0, 1, 1);
    wait_applied(0);
    capture(0, 12, pw, tk);
    chk("p0_pwm", pw, 32'hFFF);
    chk("p0_tick", tk, 32'hFFF);

    // Disable ch2 mid-high, then re-enable it directly while idle.
    do_reset(2);
    run_to(10);
    cfg_write(2, 3, 1, 0);
    run_to(16);
    chk("disable_not_truncated", 32'(pwm[2]), 32'h1);
    wait_applied(2);
    chk("disable_wrap_tick", 32'(tick[2]), 32'h1);
    capture(2, 8, pw, tk);
    chk("disabled_pwm", pw, 32'h0);
    chk("disabled_tick", tk, 32'h0);
    cfg_write(2, 3, 1, 1);
    chk("reenable_edge_pwm", 32'(pwm[2]), 32'h0);
    rdy_of(2, r);
    chk("reenable_no_pending", 32'(r), 32'h1);
    capture(2, 8, pw, tk);
    chk("reenable_pwm", pw, 32'b00010001);
    chk("reenable_tick", tk, 32'b10001000);
    chk("reenable_others", 32'(pwm), 32'b1011);

    // Reset with a write pending discards it.
    do_reset(3);
    run_to(50);
    cfg_write(3, 9, 3, 1);
    do_reset(3);
    run_to(195);
    chk("post_reset_high", 32'(pwm), 32'hF);
    run_to(196);
    chk("post_reset_low", 32'(pwm), 32'h0);
    run_to(391);
    chk("post_reset_tick", 32'(tick), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/pwm_divider_bank.md
PWM_DIVIDER_BANK -- requirements
Module: pwm_divider_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent divider/PWM channels, range 1-16.
REQ-002 Parameter WIDTH, default 16: counter, period and high-time width in bits, range 4-32.
REQ-003 Parameter DEFAULT_PERIOD, default 390: period value loaded into every channel at reset.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 cfg_valid  input  1  configuration write request.
REQ-008 cfg_ready  output  1  write can be accepted this cycle; a write is accepted when cfg_valid && cfg_ready.
REQ-009 cfg_chan  input  max(1,clog2(CHANNELS))  target channel index.
REQ-010 cfg_period  input  WIDTH  terminal count P; the channel period is P+1 clock cycles.
REQ-011 cfg_high  input  WIDTH  high time H in cycles.
REQ-012 cfg_enable  input  1  channel enable.
REQ-013 pwm_out  output  CHANNELS  registered per-channel PWM/divided clock.
REQ-014 period_tick  output  CHANNELS  registered one-cycle pulse per channel wrap.

Function
REQ-015 Each channel SHALL hold active registers (period, high, enable), a shadow set of the same fields, a pending flag and a WIDTH-bit counter.
REQ-016 Enabled channel: counter SHALL increment by 1 per cycle and return to 0 in the cycle after it equals the active period (wrap).
REQ-017 pwm_out[c] SHALL be registered as (enable && counter < high), evaluated on the pre-edge counter value; latency is one cycle from counter to output.
REQ-018 period_tick[c] SHALL be 1 for exactly the one cycle after the counter equals the active period, and 0 otherwise.
REQ-019 cfg_ready SHALL be combinational: 0 when cfg_chan < CHANNELS and that channel's pending flag is 1, otherwise 1.
REQ-020 Accepted write to an enabled channel SHALL load the shadow set and set pending; no active field changes before the wrap.
REQ-021 At a wrap with pending set, active SHALL be loaded from shadow, the counter SHALL go to 0, and pending SHALL clear in the same edge.
REQ-022 Accepted write in the same cycle as that channel's wrap SHALL take effect at that wrap, and the counter SHALL restart at 0 under the new values.
REQ-023 Accepted write to a disabled channel SHALL load active directly at the next edge and set the counter to 0, without using pending.
REQ-024 Disabled channel: counter SHALL be held at 0, and pwm_out and period_tick SHALL be 0.
REQ-025 Disable written to an enabled channel SHALL take effect at the next wrap, so no partial high pulse is truncated.
REQ-026 If H = 0, pwm_out SHALL stay 0; if H > P, pwm_out SHALL stay 1 while enabled.
REQ-027 If P = 0, the counter SHALL remain 0, period_tick SHALL be 1 every cycle, and pwm_out SHALL equal (H > 0).
REQ-028 cfg_chan >= CHANNELS SHALL be accepted (cfg_ready = 1) and ignored.
REQ-029 Counter arithmetic SHALL be WIDTH-bit unsigned; P = 2^WIDTH-1 SHALL wrap correctly without overflow.
REQ-030 Channels SHALL be fully independent; a write to one channel SHALL NOT disturb any other channel's counter or outputs.

Reset
REQ-031 On reset = 1 at the edge, every channel SHALL load: counter 0, active period DEFAULT_PERIOD, active high DEFAULT_PERIOD/2 (integer division), enable 1, pending 0, shadow = active.
REQ-032 During and after reset, pwm_out and period_tick SHALL be 0 until the first post-reset counter evaluation.
REQ-033 Reset asserted mid-period or with a write pending SHALL discard the pending write, and reset values SHALL apply.
REQ-034 cfg_valid during reset SHALL be ignored.

Verification
REQ-035 Default run: release reset, no writes -> each pwm_out is high 195 cycles then low 196, and period_tick pulses every 391 cycles.
REQ-036 Write ch1 with P=9, H=3 mid-period -> old waveform completes, then ch1 shows 3 high / 7 low, tick every 10 cycles; other channels are unchanged.
REQ-037 Second write to ch1 while pending -> cfg_ready=0 for cfg_chan=1 and =1 for cfg_chan=2 in the same cycle; after the wrap, cfg_ready=1.
REQ-038 Edge values on ch0: H=0 -> pwm_out constant 0; P=4, H=7 -> constant 1; P=0, H=1 -> pwm_out=1 and tick every cycle.
REQ-039 Write issued in the exact wrap cycle (P=5, H=2) -> next counter value is 0 and the new waveform starts immediately.
REQ-040 Disable ch2, then re-enable it with P=3, H=1 while disabled -> outputs are 0 while disabled; re-enable applies next edge, first high pulse one cycle later, period 4.
